// File: rtl/uart_cmd_link.sv
// uart_cmd_link: robot-side UART command link; 8N1 byte pairs in (high byte first) -> 16-bit cmd, 8-bit responses out.
// Latency: cmd/cmd_rdy update 1 clk after the 2nd byte's stop-bit sample; tx_done rises 10*BAUD_DIV clks after send_resp.
// Backpressure: none on RX (a new command overwrites cmd); send_resp is ignored while a response is being sent.
// Optional feature: define BYTE_TIMEOUT_EN to drop a lone high byte after TMO_CLKS idle clocks.
module uart_cmd_link #(
    parameter int BAUD_DIV = 2604,
    parameter int TMO_CLKS = 1000000
) (
    input  logic        clk,
    input  logic        RST_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        tx_done,
    output logic        frm_err
);

    // Reject configurations the 12-bit baud counters cannot represent.
    if (BAUD_DIV < 16 || BAUD_DIV > 4095 || TMO_CLKS < 1) begin : g_param_check
        $error("uart_cmd_link: BAUD_DIV must be 16..4095 and TMO_CLKS >= 1");
    end

    localparam logic [11:0] BAUD_FULL = 12'(BAUD_DIV);
    localparam logic [11:0] BAUD_HALF = 12'(BAUD_DIV / 2);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [0:0] TX_IDLE  = 1'b0;
    localparam logic [0:0] TX_XMIT  = 1'b1;

    // ---------------------------------------------------------------- RX path
    logic        rx_meta_q;
    logic        rx_sync_q;
    logic [1:0]  rx_state_q, rx_state_d;
    logic [11:0] rx_cnt_q,   rx_cnt_d;
    logic [3:0]  rx_bit_q,   rx_bit_d;
    logic [7:0]  rx_sh_q,    rx_sh_d;
    logic        rx_expire;
    logic        rx_start_ok;
    logic        rx_byte_vld;
    logic        rx_stop_bad;

    // Two-flop synchroniser; presets to idle-high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
        end
    end

    assign rx_expire = (rx_cnt_q == 12'd1);

    // RX framing FSM: half-bit delay to centre on the start bit, then one sample per bit period.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_sh_d     = rx_sh_q;
        rx_start_ok = 1'b0;
        rx_byte_vld = 1'b0;
        rx_stop_bad = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = BAUD_HALF;
                end
            end
            RX_START: begin
                if (rx_expire) begin
                    if (rx_sync_q) begin
                        // Line went back high before mid start bit: a glitch, not a frame.
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d  = RX_DATA;
                        rx_cnt_d    = BAUD_FULL;
                        rx_bit_d    = 4'd0;
                        rx_start_ok = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 12'd1;
                end
            end
            RX_DATA: begin
                if (rx_expire) begin
                    rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
                    rx_cnt_d = BAUD_FULL;
                    if (rx_bit_q == 4'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 4'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 12'd1;
                end
            end
            RX_STOP: begin
                if (rx_expire) begin
                    rx_state_d  = RX_IDLE;
                    rx_cnt_d    = BAUD_FULL;
                    rx_byte_vld = rx_sync_q;
                    rx_stop_bad = ~rx_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q - 12'd1;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // RX FSM state registers.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= 12'd0;
            rx_bit_q   <= 4'd0;
            rx_sh_q    <= 8'd0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
        end
    end

    // ------------------------------------------------------- Byte assembly
    logic        byte_sel_q, byte_sel_d;
    logic [7:0]  cmd_hi_q,   cmd_hi_d;
    logic [15:0] cmd_q,      cmd_d;
    logic        cmd_rdy_q,  cmd_rdy_d;
    logic        frm_err_q,  frm_err_d;
    logic        tmo_hit;

`ifdef BYTE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CLKS + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Idle timer armed while a high byte waits for its partner; any confirmed start bit restarts it.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        tmo_hit   = 1'b0;
        if (!byte_sel_q || rx_start_ok) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_W'(TMO_CLKS - 1)) begin
            tmo_hit   = 1'b1;
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Pair bytes into a command; a set of cmd_rdy overrides any clear in the same cycle.
    always_comb begin
        byte_sel_d = byte_sel_q;
        cmd_hi_d   = cmd_hi_q;
        cmd_d      = cmd_q;
        cmd_rdy_d  = cmd_rdy_q;
        frm_err_d  = rx_stop_bad;
        if (tmo_hit) begin
            byte_sel_d = 1'b0;
        end
        if (rx_start_ok && !byte_sel_q) begin
            cmd_rdy_d = 1'b0;
        end
        if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end
        if (rx_byte_vld) begin
            if (!byte_sel_q) begin
                cmd_hi_d   = rx_sh_q;
                byte_sel_d = 1'b1;
            end else begin
                cmd_d      = {cmd_hi_q, rx_sh_q};
                cmd_rdy_d  = 1'b1;
                byte_sel_d = 1'b0;
            end
        end
    end

    // Command-side registers.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            byte_sel_q <= 1'b0;
            cmd_hi_q   <= 8'd0;
            cmd_q      <= 16'd0;
            cmd_rdy_q  <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            byte_sel_q <= byte_sel_d;
            cmd_hi_q   <= cmd_hi_d;
            cmd_q      <= cmd_d;
            cmd_rdy_q  <= cmd_rdy_d;
            frm_err_q  <= frm_err_d;
        end
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;
    assign frm_err = frm_err_q;

    // ---------------------------------------------------------------- TX path
    logic [0:0]  tx_state_q, tx_state_d;
    logic [11:0] tx_cnt_q,   tx_cnt_d;
    logic [3:0]  tx_bit_q,   tx_bit_d;
    logic [9:0]  tx_sh_q,    tx_sh_d;
    logic        tx_done_q,  tx_done_d;

    // TX FSM: load {stop, data, start}, shift out LSB first with ones backfilled so the line idles high.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_done_d  = tx_done_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (send_resp) begin
                    tx_sh_d    = {1'b1, resp, 1'b0};
                    tx_cnt_d   = BAUD_FULL;
                    tx_bit_d   = 4'd0;
                    tx_done_d  = 1'b0;
                    tx_state_d = TX_XMIT;
                end
            end
            TX_XMIT: begin
                if (tx_cnt_q == 12'd1) begin
                    tx_cnt_d = BAUD_FULL;
                    tx_sh_d  = {1'b1, tx_sh_q[9:1]};
                    if (tx_bit_q == 4'd9) begin
                        tx_done_d  = 1'b1;
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 12'd1;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    // TX registers; the shift register resets to all ones so TX idles high.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= 12'd0;
            tx_bit_q   <= 4'd0;
            tx_sh_q    <= 10'h3FF;
            tx_done_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign TX      = tx_sh_q[0];
    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_cmd_link.sv
// Bench for uart_cmd_link: drives 8N1 frames on RX, checks cmd/cmd_rdy/frm_err and TX framing
// against a byte-level model (expected command value, expected bit list {1,resp,0}).
module tb_uart_cmd_link;

    localparam int B   = 32;
    localparam int TMO = 600;

    logic        clk = 1'b0;
    logic        RST_n = 1'b1;
    logic        RX = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        tx_done;
    logic        frm_err;

    int          n_vec = 0;
    int          n_err = 0;
    int          frm_cnt = 0;
    logic        rdy_at_stop;
    logic [15:0] exp_cmd = 16'h0000;

    uart_cmd_link #(.BAUD_DIV(B), .TMO_CLKS(TMO)) dut (
        .clk(clk), .RST_n(RST_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
        .tx_done(tx_done), .frm_err(frm_err)
    );

    always #5 clk = ~clk;

    // Count frm_err pulses, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (frm_err === 1'b1) frm_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One 8N1 frame, LSB first, followed by one idle bit time. A bad frame holds the stop bit
    // low past its centre and then releases the line.
    task automatic send_byte(input logic [7:0] b, input bit good);
        @(negedge clk);
        RX = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (B) @(negedge clk);
        end
        rdy_at_stop = cmd_rdy;
        if (good) begin
            RX = 1'b1;
            repeat (B) @(negedge clk);
        end else begin
            RX = 1'b0;
            repeat (3 * B / 4) @(negedge clk);
            RX = 1'b1;
            repeat (B / 4) @(negedge clk);
        end
        repeat (B) @(negedge clk);
    endtask

    task automatic pulse_clr;
        @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic test_reset;
        #1 RST_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (TX !== 1'b1)       begin n_err++; $display("FAIL reset_tx got=%b exp=1", TX); end
        n_vec++; if (cmd !== 16'h0000)  begin n_err++; $display("FAIL reset_cmd got=%h exp=0000", cmd); end
        n_vec++; if (cmd_rdy !== 1'b0)  begin n_err++; $display("FAIL reset_cmd_rdy got=%b exp=0", cmd_rdy); end
        n_vec++; if (tx_done !== 1'b0)  begin n_err++; $display("FAIL reset_tx_done got=%b exp=0", tx_done); end
        n_vec++; if (frm_err !== 1'b0)  begin n_err++; $display("FAIL reset_frm_err got=%b exp=0", frm_err); end
        RST_n = 1'b1;
        exp_cmd = 16'h0000;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_cmd_rx;
        logic [7:0] hi, lo;
        for (int t = 0; t < 6; t++) begin
            hi = (t == 0) ? 8'h29 : 8'($urandom);
            lo = (t == 0) ? 8'h30 : 8'($urandom);
            send_byte(hi, 1'b1);
            n_vec++; if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL rx_rdy_after_hi t=%0d got=%b exp=0", t, cmd_rdy); end
            n_vec++; if (cmd !== exp_cmd)  begin n_err++; $display("FAIL rx_cmd_hold t=%0d got=%h exp=%h", t, cmd, exp_cmd); end
            send_byte(lo, 1'b1);
            exp_cmd = {hi, lo};
            n_vec++; if (rdy_at_stop !== 1'b0) begin n_err++; $display("FAIL rx_rdy_early t=%0d got=%b exp=0", t, rdy_at_stop); end
            n_vec++; if (cmd_rdy !== 1'b1) begin n_err++; $display("FAIL rx_rdy t=%0d got=%b exp=1", t, cmd_rdy); end
            n_vec++; if (cmd !== exp_cmd)  begin n_err++; $display("FAIL rx_cmd t=%0d got=%h exp=%h", t, cmd, exp_cmd); end
            repeat (3 * B) @(negedge clk);
            n_vec++; if (cmd_rdy !== 1'b1) begin n_err++; $display("FAIL rx_rdy_sticky t=%0d got=%b exp=1", t, cmd_rdy); end
            // Odd passes leave cmd_rdy set so the next high byte's start bit must clear it.
            if (t % 2 == 0) begin
                pulse_clr();
                n_vec++; if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL rx_clr t=%0d got=%b exp=0", t, cmd_rdy); end
            end
        end
        pulse_clr();
    endtask

    task automatic test_glitch;
        logic [7:0] hi, lo;
        int f0;
        f0 = frm_cnt;
        @(negedge clk);
        RX = 1'b0;
        repeat (B / 4) @(negedge clk);
        RX = 1'b1;
        repeat (2 * B) @(negedge clk);
        n_vec++; if (cmd_rdy !== 1'b0)  begin n_err++; $display("FAIL glitch_rdy got=%b exp=0", cmd_rdy); end
        n_vec++; if (cmd !== exp_cmd)   begin n_err++; $display("FAIL glitch_cmd got=%h exp=%h", cmd, exp_cmd); end
        n_vec++; if (frm_cnt !== f0)    begin n_err++; $display("FAIL glitch_frm got=%0d exp=%0d", frm_cnt, f0); end
        // If the glitch had been taken as a byte, the next pair would be misaligned.
        hi = 8'($urandom);
        lo = 8'($urandom);
        send_byte(hi, 1'b1);
        send_byte(lo, 1'b1);
        exp_cmd = {hi, lo};
        n_vec++; if (cmd !== exp_cmd)   begin n_err++; $display("FAIL glitch_pair got=%h exp=%h", cmd, exp_cmd); end
        pulse_clr();
    endtask

    task automatic test_frm_err;
        int f0;
        f0 = frm_cnt;
        send_byte(8'h12, 1'b0);
        n_vec++; if (frm_cnt !== f0 + 1) begin n_err++; $display("FAIL frm_pulse got=%0d exp=%0d", frm_cnt, f0 + 1); end
        n_vec++; if (cmd !== exp_cmd)    begin n_err++; $display("FAIL frm_cmd_hold got=%h exp=%h", cmd, exp_cmd); end
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        exp_cmd = 16'h1234;
        n_vec++; if (cmd !== exp_cmd)    begin n_err++; $display("FAIL frm_cmd got=%h exp=%h", cmd, exp_cmd); end
        n_vec++; if (cmd_rdy !== 1'b1)   begin n_err++; $display("FAIL frm_rdy got=%b exp=1", cmd_rdy); end
        n_vec++; if (frm_cnt !== f0 + 1) begin n_err++; $display("FAIL frm_once got=%0d exp=%0d", frm_cnt, f0 + 1); end
        pulse_clr();
    endtask

    task automatic test_resp_tx;
        logic [7:0] r;
        logic [9:0] fr;
        for (int t = 0; t < 4; t++) begin
            r  = (t == 0) ? 8'hA5 : 8'($urandom);
            fr = {1'b1, r, 1'b0};
            @(negedge clk);
            resp = r;
            send_resp = 1'b1;
            @(negedge clk);
            send_resp = 1'b0;
            for (int k = 0; k < 10 * B; k++) begin
                if (k % B == 0 || k % B == B - 1) begin
                    n_vec++;
                    if (TX !== fr[k / B]) begin n_err++; $display("FAIL tx_bit t=%0d k=%0d got=%b exp=%b", t, k, TX, fr[k / B]); end
                end
                if (k == 0 || k == 10 * B - 1) begin
                    n_vec++;
                    if (tx_done !== 1'b0) begin n_err++; $display("FAIL tx_done_early t=%0d k=%0d got=%b exp=0", t, k, tx_done); end
                end
                @(negedge clk);
            end
            n_vec++; if (tx_done !== 1'b1) begin n_err++; $display("FAIL tx_done t=%0d got=%b exp=1", t, tx_done); end
            n_vec++; if (TX !== 1'b1)      begin n_err++; $display("FAIL tx_idle t=%0d got=%b exp=1", t, TX); end
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
    endtask

    task automatic test_send_ignored;
        logic [9:0] fr;
        fr = {1'b1, 8'h5A, 1'b0};
        @(negedge clk);
        resp = 8'h5A;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        for (int k = 0; k < 10 * B; k++) begin
            if (k == 3 * B) begin resp = 8'hA5; send_resp = 1'b1; end
            if (k == 3 * B + 1) send_resp = 1'b0;
            if (k % B == B / 2) begin
                n_vec++;
                if (TX !== fr[k / B]) begin n_err++; $display("FAIL ign_bit k=%0d got=%b exp=%b", k, TX, fr[k / B]); end
            end
            @(negedge clk);
        end
        n_vec++; if (tx_done !== 1'b1) begin n_err++; $display("FAIL ign_done got=%b exp=1", tx_done); end
        repeat (2 * B) @(negedge clk);
        n_vec++; if (TX !== 1'b1)      begin n_err++; $display("FAIL ign_no_2nd_tx got=%b exp=1", TX); end
        n_vec++; if (tx_done !== 1'b1) begin n_err++; $display("FAIL ign_done_hold got=%b exp=1", tx_done); end
    endtask

    task automatic test_duplex;
        logic [7:0] hi, lo, r;
        logic [9:0] fr;
        hi = 8'($urandom);
        lo = 8'($urandom);
        r  = 8'($urandom);
        fr = {1'b1, r, 1'b0};
        fork
            begin
                send_byte(hi, 1'b1);
                send_byte(lo, 1'b1);
            end
            begin
                @(negedge clk);
                resp = r;
                send_resp = 1'b1;
                @(negedge clk);
                send_resp = 1'b0;
                for (int k = 0; k < 10 * B; k++) begin
                    if (k % B == B / 2) begin
                        n_vec++;
                        if (TX !== fr[k / B]) begin n_err++; $display("FAIL dup_bit k=%0d got=%b exp=%b", k, TX, fr[k / B]); end
                    end
                    @(negedge clk);
                end
                n_vec++; if (tx_done !== 1'b1) begin n_err++; $display("FAIL dup_done got=%b exp=1", tx_done); end
            end
        join
        exp_cmd = {hi, lo};
        n_vec++; if (cmd !== exp_cmd)  begin n_err++; $display("FAIL dup_cmd got=%h exp=%h", cmd, exp_cmd); end
        n_vec++; if (cmd_rdy !== 1'b1) begin n_err++; $display("FAIL dup_rdy got=%b exp=1", cmd_rdy); end
        pulse_clr();
    endtask

    task automatic test_reset_midframe;
        logic [7:0] hi, lo;
        send_byte(8'h77, 1'b1);
        @(negedge clk);
        RX = 1'b0;
        repeat (3 * B) @(negedge clk);
        RST_n = 1'b0;
        RX = 1'b1;
        repeat (2) @(negedge clk);
        exp_cmd = 16'h0000;
        n_vec++; if (cmd !== exp_cmd)  begin n_err++; $display("FAIL rstmid_cmd got=%h exp=%h", cmd, exp_cmd); end
        n_vec++; if (tx_done !== 1'b0) begin n_err++; $display("FAIL rstmid_done got=%b exp=0", tx_done); end
        RST_n = 1'b1;
        repeat (2 * B) @(negedge clk);
        hi = 8'($urandom);
        lo = 8'($urandom);
        send_byte(hi, 1'b1);
        send_byte(lo, 1'b1);
        exp_cmd = {hi, lo};
        n_vec++; if (cmd !== exp_cmd)  begin n_err++; $display("FAIL rstmid_pair got=%h exp=%h", cmd, exp_cmd); end
        pulse_clr();
    endtask

    task automatic test_timeout;
        send_byte(8'hAB, 1'b1);
        repeat (TMO + 10) @(negedge clk);
`ifdef BYTE_TIMEOUT_EN
        send_byte(8'h29, 1'b1);
        send_byte(8'h30, 1'b1);
        exp_cmd = 16'h2930;
`else
        send_byte(8'hCD, 1'b1);
        exp_cmd = 16'hABCD;
`endif
        n_vec++; if (cmd !== exp_cmd)  begin n_err++; $display("FAIL tmo_cmd got=%h exp=%h", cmd, exp_cmd); end
        n_vec++; if (cmd_rdy !== 1'b1) begin n_err++; $display("FAIL tmo_rdy got=%b exp=1", cmd_rdy); end
        pulse_clr();
    endtask

    initial begin
        test_reset();
        test_cmd_rx();
        test_glitch();
        test_frm_err();
        test_resp_tx();
        test_send_ignored();
        test_duplex();
        test_reset_midframe();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
